apb_region_decoder: RTL and testbench

//  Parametrised APB1-to-N address decoder/mux between core_top and memory-mapped slaves (RAM, CLINT, UART...).

---
 rtl/apb_region_decoder.sv | 152 +++++++++++++++
 tb/tb_apb_region_decoder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_region_decoder.sv
// APB 1-to-N address decoder and response mux. Each region is matched with a base/mask pair.
// Unmapped accesses and stalled slaves get an error response, and the address of the most recent error is captured.
module apb_region_decoder #(
  parameter int                             N_SLV    = 4,
  parameter int                             ADDR_W   = 34,
  parameter logic [N_SLV-1:0][ADDR_W-1:0]   SLV_BASE = '0,
  parameter logic [N_SLV-1:0][ADDR_W-1:0]   SLV_MASK = '0,
  parameter int                             TIMEOUT  = 256,
  parameter int                             CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    m_psel,
  input  logic                    m_penable,
  input  logic [ADDR_W-1:0]       m_paddr,
  input  logic                    m_pwrite,
  input  logic [31:0]             m_pwdata,
  input  logic [3:0]              m_pwstrb,
  output logic                    m_pready,
  output logic [31:0]             m_prdata,
  output logic                    m_pslverr,
  output logic [N_SLV-1:0]        s_psel,
  output logic                    s_penable,
  output logic [ADDR_W-1:0]       s_paddr,
  output logic                    s_pwrite,
  output logic [31:0]             s_pwdata,
  output logic [3:0]              s_pwstrb,
  input  logic [N_SLV-1:0]        s_pready,
  input  logic [N_SLV*32-1:0]     s_prdata,
  input  logic [N_SLV-1:0]        s_pslverr,
  output logic                    err_valid,
  output logic [ADDR_W-1:0]       err_addr,
  input  logic                    err_clr
);

  localparam int               IDX_W   = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam bit               TO_EN   = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACCESS, ERRRESP} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_valid_q, err_valid_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;

  logic                hit;
  logic [IDX_W-1:0]    hit_idx;
  logic                setup;
  logic                sel_pready;
  logic                timeout_hit;

  assign s_paddr   = m_paddr;
  assign s_pwrite  = m_pwrite;
  assign s_pwdata  = m_pwdata;
  assign s_pwstrb  = m_pwstrb;
  assign err_valid = err_valid_q;
  assign err_addr  = err_addr_q;

  assign setup       = m_psel & ~m_penable;
  assign sel_pready  = s_pready[idx_q];
  assign timeout_hit = TO_EN && (cnt_q == CNT_MAX) && !sel_pready;

  // Scan from the top index down so the lowest matching region is the one left standing.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if (((m_paddr ^ SLV_BASE[i]) & SLV_MASK[i]) == '0) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    s_psel    = '0;
    s_penable = 1'b0;
    m_pready  = 1'b0;
    m_pslverr = 1'b0;
    m_prdata  = '0;
    unique case (state_q)
      IDLE: begin
        if (setup) begin
          if (hit) s_psel[hit_idx] = 1'b1;
          idx_d   = hit_idx;
          cnt_d   = '0;
          state_d = hit ? ACCESS : ERRRESP;
        end
      end
      ACCESS: begin
        if (!m_psel) begin
          // The master abandoned the transfer, so there is no response and no error capture.
          state_d = IDLE;
        end else if (timeout_hit) begin
          m_pready  = 1'b1;
          m_pslverr = 1'b1;
          state_d   = IDLE;
        end else begin
          s_psel[idx_q] = 1'b1;
          s_penable     = m_penable;
          m_pready      = sel_pready;
          m_pslverr     = s_pslverr[idx_q];
          m_prdata      = s_prdata[32*idx_q +: 32];
          if (sel_pready)            state_d = IDLE;
          else if (cnt_q != CNT_MAX) cnt_d   = cnt_q + 1'b1;
        end
      end
      ERRRESP: begin
        m_pready  = 1'b1;
        m_pslverr = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A new error takes priority over a clear in the same cycle.
  always_comb begin
    err_valid_d = err_valid_q;
    err_addr_d  = err_addr_q;
    if (m_pready && m_pslverr) begin
      err_valid_d = 1'b1;
      err_addr_d  = m_paddr;
    end else if (err_clr) begin
      err_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
    end
  end

endmodule

// File: tb/tb_apb_region_decoder.sv
// Self-checking bench for apb_region_decoder. It uses two regions and TIMEOUT=8.
// Directed scenarios and random transfers are checked against a transfer-level reference model.
module tb_apb_region_decoder;

  localparam int N_SLV   = 2;
  localparam int ADDR_W  = 34;
  localparam int TIMEOUT = 8;
  localparam logic [N_SLV-1:0][ADDR_W-1:0] BASE = {34'h0_0200_0000, 34'h0_8000_0000};
  localparam logic [N_SLV-1:0][ADDR_W-1:0] MASK = {34'h3_FFFF_0000, 34'h3_8000_0000};

  logic                clk = 1'b0;
  logic                rst_n;
  logic                m_psel, m_penable, m_pwrite;
  logic [ADDR_W-1:0]   m_paddr;
  logic [31:0]         m_pwdata;
  logic [3:0]          m_pwstrb;
  logic                m_pready, m_pslverr;
  logic [31:0]         m_prdata;
  logic [N_SLV-1:0]    s_psel;
  logic                s_penable, s_pwrite;
  logic [ADDR_W-1:0]   s_paddr;
  logic [31:0]         s_pwdata;
  logic [3:0]          s_pwstrb;
  logic [N_SLV-1:0]    s_pready, s_pslverr;
  logic [N_SLV*32-1:0] s_prdata;
  logic                err_valid, err_clr;
  logic [ADDR_W-1:0]   err_addr;

  int errors = 0;
  int checks = 0;

  logic              exp_err_valid;
  logic [ADDR_W-1:0] exp_err_addr;
  logic [31:0]       slv_data [N_SLV];
  logic              clr_during;

  apb_region_decoder #(
    .N_SLV(N_SLV), .ADDR_W(ADDR_W), .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_psel(m_psel), .m_penable(m_penable), .m_paddr(m_paddr), .m_pwrite(m_pwrite),
    .m_pwdata(m_pwdata), .m_pwstrb(m_pwstrb),
    .m_pready(m_pready), .m_prdata(m_prdata), .m_pslverr(m_pslverr),
    .s_psel(s_psel), .s_penable(s_penable), .s_paddr(s_paddr), .s_pwrite(s_pwrite),
    .s_pwdata(s_pwdata), .s_pwstrb(s_pwstrb),
    .s_pready(s_pready), .s_prdata(s_prdata), .s_pslverr(s_pslverr),
    .err_valid(err_valid), .err_addr(err_addr), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Reference decode: the lowest region whose masked bits equal the base, or -1 if none matches.
  function automatic int exp_region(input logic [ADDR_W-1:0] addr);
    for (int i = 0; i < N_SLV; i++)
      if (((addr ^ BASE[i]) & MASK[i]) == '0) return i;
    return -1;
  endfunction

  // A full transfer. Every slave raises pready after `waits` wait cycles and returns its own data.
  task automatic run_xfer(input string name, input logic [ADDR_W-1:0] addr, input logic wr,
                          input logic [31:0] wdata, input logic [3:0] strb, input int waits,
                          input logic [N_SLV-1:0] serr);
    int               region;
    int               done_cyc;
    bit               err_path;
    logic [N_SLV-1:0] sel;
    logic             exp_perr;
    logic [31:0]      exp_rd;
    region   = exp_region(addr);
    sel      = (region < 0) ? '0 : N_SLV'(1 << region);
    err_path = (region < 0) || (waits > TIMEOUT);
    done_cyc = (region < 0) ? 1 : ((waits <= TIMEOUT) ? waits + 1 : TIMEOUT + 1);
    exp_perr = err_path ? 1'b1 : serr[region];
    exp_rd   = err_path ? 32'h0 : slv_data[region];

    @(posedge clk); #1;
    m_psel = 1'b1; m_penable = 1'b0; m_paddr = addr; m_pwrite = wr;
    m_pwdata = wdata; m_pwstrb = strb; s_pready = '0; s_pslverr = serr; err_clr = 1'b0;
    s_prdata = {slv_data[1], slv_data[0]};
    #4;
    checks++;
    if (s_psel !== sel) begin
      errors++; $display("FAIL %s setup_sel: got %b want %b", name, s_psel, sel);
    end
    checks++;
    if ({s_penable, m_pready} !== 2'b00) begin
      errors++; $display("FAIL %s setup_idle: penable/pready got %b want 00", name, {s_penable, m_pready});
    end
    checks++;
    if ({err_valid, err_addr} !== {exp_err_valid, exp_err_addr}) begin
      errors++; $display("FAIL %s err_state: got %b/%h want %b/%h", name, err_valid, err_addr,
                         exp_err_valid, exp_err_addr);
    end

    for (int c = 1; c <= TIMEOUT + 4; c++) begin
      @(posedge clk); #1;
      m_penable = 1'b1; err_clr = clr_during;
      s_pready  = (c > waits) ? '1 : '0;
      #4;
      if (c == done_cyc) begin
        checks++;
        if ({m_pready, m_pslverr, m_prdata} !== {1'b1, exp_perr, exp_rd}) begin
          errors++; $display("FAIL %s resp: got rdy=%b err=%b rd=%h want rdy=1 err=%b rd=%h",
                             name, m_pready, m_pslverr, m_prdata, exp_perr, exp_rd);
        end
        checks++;
        if (s_psel !== (err_path ? '0 : sel)) begin
          errors++; $display("FAIL %s done_sel: got %b want %b", name, s_psel, err_path ? '0 : sel);
        end
        if (exp_perr) begin
          exp_err_valid = 1'b1; exp_err_addr = addr;
        end else if (clr_during) begin
          exp_err_valid = 1'b0;
        end
        break;
      end
      checks++;
      if ({m_pready, s_psel, s_penable} !== {1'b0, sel, 1'b1}) begin
        errors++; $display("FAIL %s wait_c%0d: rdy/sel/en got %b want %b", name, c,
                           {m_pready, s_psel, s_penable}, {1'b0, sel, 1'b1});
      end
      checks++;
      if ({s_paddr, s_pwrite, s_pwdata, s_pwstrb} !== {addr, wr, wdata, strb}) begin
        errors++; $display("FAIL %s passthru: got %h/%b/%h/%h want %h/%b/%h/%h", name, s_paddr,
                           s_pwrite, s_pwdata, s_pwstrb, addr, wr, wdata, strb);
      end
      if (clr_during) exp_err_valid = 1'b0;
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    m_psel = 1'b0; m_penable = 1'b0; s_pready = '0; err_clr = 1'b0;
    #4;
    checks++;
    if ({s_psel, m_pready} !== '0) begin
      errors++; $display("FAIL idle: sel/pready got %b want 0", {s_psel, m_pready});
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({s_psel, s_penable, m_pready, m_pslverr, m_prdata, err_valid, err_addr} !== '0) begin
      errors++; $display("FAIL reset: sel=%b en=%b rdy=%b err=%b rd=%h ev=%b ea=%h want all 0",
                         s_psel, s_penable, m_pready, m_pslverr, m_prdata, err_valid, err_addr);
    end
  endtask

  task automatic test_read_slave0();
    slv_data[0] = 32'hDEADBEEF; slv_data[1] = 32'h0BAD_0001; clr_during = 1'b0;
    run_xfer("read_s0", 34'h0_8000_0010, 1'b0, 32'h0, 4'h0, 2, 2'b00);
    idle_cycle();
  endtask

  task automatic test_write_slave1();
    slv_data[0] = 32'h1111_0000; slv_data[1] = 32'h2222_0000;
    run_xfer("write_s1", 34'h0_0200_4000, 1'b1, 32'h12345678, 4'hF, 1, 2'b00);
    idle_cycle();
  endtask

  task automatic test_unmapped();
    run_xfer("unmapped", 34'h0_1000_0000, 1'b0, 32'h0, 4'h0, 0, 2'b00);
    idle_cycle();
  endtask

  task automatic test_timeout();
    run_xfer("timeout", 34'h0_8000_0100, 1'b0, 32'h0, 4'h0, 50, 2'b00);
    idle_cycle();
    run_xfer("ready_at_limit", 34'h0_8000_0200, 1'b0, 32'h0, 4'h0, TIMEOUT, 2'b00);
    idle_cycle();
  endtask

  task automatic test_err_clr();
    @(posedge clk); #1; err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
    exp_err_valid = 1'b0;
    #4;
    checks++;
    if ({err_valid, err_addr} !== {1'b0, exp_err_addr}) begin
      errors++; $display("FAIL err_clr: got %b/%h want 0/%h", err_valid, err_addr, exp_err_addr);
    end
    clr_during = 1'b1;
    run_xfer("clr_vs_err", 34'h0_0200_0040, 1'b0, 32'h0, 4'h0, 1, 2'b10);
    clr_during = 1'b0;
    idle_cycle();
  endtask

  task automatic test_reset_mid_access();
    @(posedge clk); #1;
    m_psel = 1'b1; m_penable = 1'b0; m_paddr = 34'h0_8000_0020; s_pready = '0;
    @(posedge clk); #1; m_penable = 1'b1;
    @(posedge clk); #2; rst_n = 1'b0;
    #1;
    checks++;
    if ({s_psel, m_pready, err_valid, err_addr} !== '0) begin
      errors++; $display("FAIL reset_mid: sel=%b rdy=%b ev=%b ea=%h want 0", s_psel, m_pready,
                         err_valid, err_addr);
    end
    exp_err_valid = 1'b0; exp_err_addr = '0;
    @(posedge clk); #1; m_psel = 1'b0; m_penable = 1'b0;
    #2; rst_n = 1'b1;
    slv_data[0] = 32'hA5A5_0F0F;
    run_xfer("after_reset", 34'h0_8000_0030, 1'b0, 32'h0, 4'h0, 0, 2'b00);
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    slv_data[0] = 32'hCAFE_0000; slv_data[1] = 32'hBEEF_0001;
    run_xfer("b2b_s1", 34'h0_0200_0010, 1'b0, 32'h0, 4'h0, 0, 2'b00);
    run_xfer("b2b_s0", 34'h0_8000_0020, 1'b0, 32'h0, 4'h0, 0, 2'b00);
    idle_cycle();
  endtask

  task automatic test_abort();
    @(posedge clk); #1;
    m_psel = 1'b1; m_penable = 1'b0; m_paddr = 34'h0_0200_0080; s_pready = '0;
    @(posedge clk); #1; m_penable = 1'b1;
    @(posedge clk); #1; m_psel = 1'b0; m_penable = 1'b0;
    #4;
    checks++;
    if ({s_psel, m_pready} !== '0) begin
      errors++; $display("FAIL abort: sel/pready got %b want 0", {s_psel, m_pready});
    end
    run_xfer("after_abort", 34'h0_0200_0084, 1'b0, 32'h0, 4'h0, 0, 2'b00);
    idle_cycle();
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] a;
    int                kind;
    for (int n = 0; n < 40; n++) begin
      a    = {2'($urandom_range(0, 3)), 32'($urandom)};
      kind = $urandom_range(0, 2);
      if (kind == 0)      a = BASE[0] | (a & ~MASK[0]);
      else if (kind == 1) a = BASE[1] | (a & ~MASK[1]);
      slv_data[0] = $urandom; slv_data[1] = $urandom;
      clr_during  = ($urandom_range(0, 7) == 0);
      run_xfer($sformatf("rand%0d", n), a, 1'($urandom_range(0, 1)), $urandom,
               4'($urandom_range(0, 15)), $urandom_range(0, 11), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    clr_during = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; m_psel = 1'b0; m_penable = 1'b0; m_paddr = '0; m_pwrite = 1'b0;
    m_pwdata = '0; m_pwstrb = '0; s_pready = '0; s_prdata = '0; s_pslverr = '0; err_clr = 1'b0;
    slv_data[0] = '0; slv_data[1] = '0; clr_during = 1'b0;
    exp_err_valid = 1'b0; exp_err_addr = '0;
    #2;
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    test_read_slave0();
    test_write_slave1();
    test_unmapped();
    test_timeout();
    test_err_clr();
    test_reset_mid_access();
    test_back_to_back();
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
